// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, byte-wide, big-endian memory between the fetch
//   port (read-only) and the data port (read/write). Each granted word request
//   becomes four byte beats on the memory. The bytes are assembled into, or
//   split out of, a 32-bit word. Completion and error status go back to the
//   requester that owns the transaction.
//
// Ports
//   clk, reset             clock; synchronous active-high reset
//   f_req/f_addr           fetch request and word byte address
//   f_gnt                  fetch accepted this cycle (combinational, IDLE only)
//   f_done/f_err/f_rdata   fetch completion pulse, fault flag, fetched word
//   d_req/d_we/d_addr/d_wdata  data request, write enable, address, write data
//   d_gnt                  data accepted this cycle (combinational, IDLE only)
//   d_done/d_err/d_rdata   data completion pulse, fault flag, load word
//   mem_addr/mem_we/mem_wdata  byte port to memory (registered)
//   mem_rdata              byte read data, valid one cycle after mem_addr
//   busy                   arbiter is not IDLE
module mem_port_arbiter #(
  parameter int AW        = 8,
  parameter int MEM_BYTES = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_done,
  output logic          f_err,
  output logic [31:0]   f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic          d_err,
  output logic [31:0]   d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_XFER  = 3'd1,
    S_DRAIN = 3'd2,
    S_ERR   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic          OWN_FETCH = 1'b0;
  localparam logic          OWN_DATA  = 1'b1;
  localparam logic [AW-1:0] MAX_BASE  = AW'(MEM_BYTES - 4);

  state_t        state_q,      state_d;
  logic          owner_q,      owner_d;
  logic          last_owner_q, last_owner_d;
  logic          we_q,         we_d;
  logic [31:0]   wdata_q,      wdata_d;
  logic [1:0]    beat_q,       beat_d;
  logic [23:0]   shift_q,      shift_d;
  logic [AW-1:0] mem_addr_q,   mem_addr_d;
  logic          mem_we_q,     mem_we_d;
  logic [7:0]    mem_wdata_q,  mem_wdata_d;
  logic [31:0]   f_rdata_q,    f_rdata_d;
  logic [31:0]   d_rdata_q,    d_rdata_d;

  logic [AW-1:0] req_addr_s;
  logic          req_we_s;
  logic          fault_s;

  // Big-endian byte select: index 0 is bits 31:24, index 3 is bits 7:0.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    word_byte = w[31:24];
      2'd1:    word_byte = w[23:16];
      2'd2:    word_byte = w[15:8];
      2'd3:    word_byte = w[7:0];
      default: word_byte = 8'h00;
    endcase
  endfunction

  // Grant logic: IDLE only; on a conflict, the port that did not own the last transaction wins.
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if ((state_q == S_IDLE) && !reset) begin
      if (f_req && d_req) begin
        if (last_owner_q == OWN_DATA) begin
          f_gnt = 1'b1;
        end else begin
          d_gnt = 1'b1;
        end
      end else begin
        f_gnt = f_req;
        d_gnt = d_req;
      end
    end else begin
      f_gnt = 1'b0;
      d_gnt = 1'b0;
    end
  end

  // Granted request attributes and the alignment/range fault check.
  always_comb begin
    req_addr_s = d_gnt ? d_addr : f_addr;
    req_we_s   = d_gnt & d_we;
    fault_s    = (req_addr_s[1:0] != 2'b00) || (req_addr_s > MAX_BASE);
  end

  // Next-state and datapath computation for every flop.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    beat_d       = beat_q;
    shift_d      = shift_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    f_rdata_d    = f_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (f_gnt || d_gnt) begin
          owner_d      = d_gnt ? OWN_DATA : OWN_FETCH;
          last_owner_d = d_gnt ? OWN_DATA : OWN_FETCH;
          we_d         = req_we_s;
          wdata_d      = d_gnt ? d_wdata : 32'h0000_0000;
          beat_d       = 2'd0;
          if (fault_s) begin
            // A faulting request never touches memory; mem_addr keeps its old value.
            state_d = S_ERR;
          end else begin
            state_d     = S_XFER;
            mem_addr_d  = req_addr_s;
            mem_we_d    = req_we_s;
            mem_wdata_d = req_we_s ? d_wdata[31:24] : 8'h00;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_XFER: begin
        // The read data seen during beat k belongs to beat k-1, so beat 0 has nothing to capture.
        if (beat_q != 2'd0) begin
          shift_d = {shift_q[15:0], mem_rdata};
        end else begin
          shift_d = shift_q;
        end
        if (beat_q == 2'd3) begin
          mem_we_d = 1'b0;
          state_d  = we_q ? S_DONE : S_DRAIN;
        end else begin
          beat_d      = beat_q + 2'd1;
          mem_addr_d  = mem_addr_q + AW'(1);
          mem_we_d    = we_q;
          mem_wdata_d = we_q ? word_byte(wdata_q, beat_q + 2'd1) : mem_wdata_q;
        end
      end

      S_DRAIN: begin
        // The byte for beat 3 arrives here and completes the word.
        if (owner_q == OWN_DATA) begin
          d_rdata_d = {shift_q, mem_rdata};
        end else begin
          f_rdata_d = {shift_q, mem_rdata};
        end
        state_d = S_DONE;
      end

      S_ERR:   state_d = S_IDLE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_FETCH;
      last_owner_q <= OWN_FETCH;
      we_q         <= 1'b0;
      wdata_q      <= 32'h0000_0000;
      beat_q       <= 2'd0;
      shift_q      <= 24'h00_0000;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= 8'h00;
      f_rdata_q    <= 32'h0000_0000;
      d_rdata_q    <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      beat_q       <= beat_d;
      shift_q      <= shift_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      f_rdata_q    <= f_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Status outputs are decoded directly from the state and owner flops.
  always_comb begin
    f_done    = ((state_q == S_DONE) || (state_q == S_ERR)) && (owner_q == OWN_FETCH);
    f_err     = (state_q == S_ERR) && (owner_q == OWN_FETCH);
    d_done    = ((state_q == S_DONE) || (state_q == S_ERR)) && (owner_q == OWN_DATA);
    d_err     = (state_q == S_ERR) && (owner_q == OWN_DATA);
    busy      = (state_q != S_IDLE);
    f_rdata   = f_rdata_q;
    d_rdata   = d_rdata_q;
    mem_addr  = mem_addr_q;
    mem_we    = mem_we_q;
    mem_wdata = mem_wdata_q;
  end

endmodule
